// File: rtl/mips_fwd_pkg.sv
// rtl/mips_fwd_pkg.sv - shared forwarding select codes and shadow-entry type
package mips_fwd_pkg;

    localparam int REG_W_DEFAULT = 5;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
    localparam logic [1:0] FWD_ZERO  = 2'b11;

    // Destination/write info for one instruction in the shadow pipeline
    typedef struct packed {
        logic                     valid;
        logic [REG_W_DEFAULT-1:0] dest;
        logic                     reg_write;
        logic                     mem_read;
    } shadow_entry_t;

    localparam shadow_entry_t BUBBLE = '0;

endpackage

// File: rtl/fwd_operand_sel.sv
// rtl/fwd_operand_sel.sv - priority forwarding select for one source register
module fwd_operand_sel
    import mips_fwd_pkg::*;
#(
    parameter int REG_W = REG_W_DEFAULT
) (
    input  logic [REG_W-1:0] src,
    input  shadow_entry_t    ex_e,
    input  shadow_entry_t    mem_e,
    output logic [1:0]       sel,
    output logic             ex_load_hit
);

    logic src_nz;
    logic hit_ex;
    logic hit_mem;
    logic unused_mem_load;

    assign src_nz  = |src;
    assign hit_ex  = ex_e.valid & ex_e.reg_write & (ex_e.dest == src) & src_nz;
    assign hit_mem = mem_e.valid & mem_e.reg_write & (mem_e.dest == src) & src_nz;

    // A load that is still in EX cannot forward yet; the top turns this into a stall
    assign ex_load_hit = hit_ex & ex_e.mem_read;

    // Loads in MEM forward from MEM/WB like any other result
    assign unused_mem_load = mem_e.mem_read;

    // $0 first, then the youngest producer wins; WB hits go through the register file
    always_comb begin
        sel = FWD_REG;
        if (!src_nz) begin
            sel = FWD_ZERO;
        end else if (hit_ex) begin
            sel = FWD_EXMEM;
        end else if (hit_mem) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - forwarding select and load-use stall control
module fwd_hazard_ctrl
    import mips_fwd_pkg::*;
#(
    parameter int REG_W = REG_W_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count
);

    shadow_entry_t ex_q;
    shadow_entry_t mem_q;
    shadow_entry_t wb_q;
    shadow_entry_t id_entry;

    logic [1:0] a_sel_next;
    logic [1:0] b_sel_next;
    logic       a_ex_load_hit;
    logic       b_ex_load_hit;
    logic       advance;
    logic       unused_wb;

    fwd_operand_sel #(.REG_W(REG_W)) u_sel_a (
        .src         (id_rs),
        .ex_e        (ex_q),
        .mem_e       (mem_q),
        .sel         (a_sel_next),
        .ex_load_hit (a_ex_load_hit)
    );

    fwd_operand_sel #(.REG_W(REG_W)) u_sel_b (
        .src         (id_rt),
        .ex_e        (ex_q),
        .mem_e       (mem_q),
        .sel         (b_sel_next),
        .ex_load_hit (b_ex_load_hit)
    );

    // Flush squashes the consumer, so it overrides any load-use stall
    assign stall   = id_valid & ~flush & (a_ex_load_hit | b_ex_load_hit);
    assign advance = id_valid & ~flush & ~stall;

    assign id_entry.valid     = 1'b1;
    assign id_entry.dest      = id_dest;
    assign id_entry.reg_write = id_reg_write;
    assign id_entry.mem_read  = id_mem_read;

    // WB is tracked for completeness; its hits resolve through register-file write-before-read
    assign unused_wb = ^wb_q;

    // Advance the shadow pipeline and register the selects alongside the ID/EX data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q      <= BUBBLE;
            mem_q     <= BUBBLE;
            wb_q      <= BUBBLE;
            fwd_a_sel <= FWD_REG;
            fwd_b_sel <= FWD_REG;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (advance) begin
                ex_q      <= id_entry;
                fwd_a_sel <= a_sel_next;
                fwd_b_sel <= b_sel_next;
            end else begin
                ex_q      <= BUBBLE;
                fwd_a_sel <= FWD_REG;
                fwd_b_sel <= FWD_REG;
            end
        end
    end

    // Saturating count of stall cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - self-checking bench for fwd_hazard_ctrl
module tb_fwd_hazard_ctrl;

    localparam int REG_W   = 5;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic [REG_W-1:0] id_dest;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             flush;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             stall;
    logic [CNT_W-1:0] stall_count;

    fwd_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_dest      (id_dest),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall        (stall),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit valid;
        int dest;
        bit writes;
        bit load;
    } instr_t;

    // issued[0] is the instruction now in EX, issued[1] in MEM, issued[2] in WB
    instr_t issued[$];
    int     exp_a;
    int     exp_b;
    int     exp_cnt;
    bit     exp_stall;
    logic   act_stall;
    int     n_checks;
    int     n_pass;

    function automatic instr_t no_instr();
        instr_t r;
        r.valid = 0; r.dest = 0; r.writes = 0; r.load = 0;
        return r;
    endfunction

    function automatic void model_reset();
        issued.delete();
        for (int i = 0; i < 3; i++) issued.push_back(no_instr());
        exp_a = 0; exp_b = 0; exp_cnt = 0; exp_stall = 0;
    endfunction

    function automatic bit produces(int age, int src);
        return issued[age].valid && issued[age].writes && issued[age].dest == src;
    endfunction

    // Youngest in-flight producer that still has to be bypassed
    function automatic int model_sel(int src);
        if (src == 0) return 3;
        if (produces(0, src)) return 1;
        if (produces(1, src)) return 2;
        return 0;
    endfunction

    function automatic bit model_stall(bit v, int rs, int rt, bit fl);
        bit dep;
        dep = (rs != 0 && produces(0, rs)) || (rt != 0 && produces(0, rt));
        return v && !fl && issued[0].load && dep;
    endfunction

    // Present one ID instruction for a cycle, then follow it across the edge
    task automatic cycle(input bit v, input int rs, input int rt, input int dest,
                         input bit rw, input bit mr, input bit fl);
        instr_t n;
        id_valid = v; id_rs = rs[REG_W-1:0]; id_rt = rt[REG_W-1:0];
        id_dest = dest[REG_W-1:0]; id_reg_write = rw; id_mem_read = mr; flush = fl;
        #1;
        exp_stall = model_stall(v, rs, rt, fl);
        act_stall = stall;
        @(posedge clk);
        n = no_instr();
        if (v && !fl && !exp_stall) begin
            exp_a = model_sel(rs);
            exp_b = model_sel(rt);
            n.valid = 1; n.dest = dest; n.writes = rw; n.load = mr;
        end else begin
            exp_a = 0;
            exp_b = 0;
        end
        if (exp_stall && exp_cnt < CNT_MAX) exp_cnt++;
        issued.push_front(n);
        void'(issued.pop_back());
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        id_valid = 0; id_rs = 0; id_rt = 0; id_dest = 0;
        id_reg_write = 0; id_mem_read = 0; flush = 0;
        #2;
        n_checks++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00 || stall !== 1'b0 || stall_count !== '0)
            $display("FAIL reset_initial a=%0d b=%0d stall=%0b cnt=%0d required 0/0/0/0",
                     fwd_a_sel, fwd_b_sel, stall, stall_count);
        else n_pass++;
        do_reset();
        cycle(1, 1, 2, 5, 1, 0, 0);
        cycle(1, 5, 0, 6, 1, 1, 0);
        id_valid = 1; id_rs = 6; id_rt = 0; id_reg_write = 0; id_mem_read = 0; flush = 0;
        #1;
        n_checks++;
        if (fwd_a_sel !== 2'b01 || stall !== 1'b1)
            $display("FAIL reset_pre a=%0d stall=%0b required 1/1", fwd_a_sel, stall);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00 || stall !== 1'b0 || stall_count !== '0)
            $display("FAIL reset_async a=%0d b=%0d stall=%0b cnt=%0d required 0/0/0/0",
                     fwd_a_sel, fwd_b_sel, stall, stall_count);
        else n_pass++;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        cycle(1, 1, 2, 3, 1, 0, 0);
        cycle(1, 3, 4, 8, 1, 0, 0);
        n_checks++;
        if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b00)
            $display("FAIL b2b_adjacent a=%0d b=%0d required 1/0", fwd_a_sel, fwd_b_sel);
        else n_pass++;
        cycle(1, 1, 2, 3, 1, 0, 0);
        cycle(1, 1, 2, 9, 1, 0, 0);
        cycle(1, 3, 4, 8, 1, 0, 0);
        n_checks++;
        if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b00)
            $display("FAIL b2b_gap1 a=%0d b=%0d required 2/0", fwd_a_sel, fwd_b_sel);
        else n_pass++;
        cycle(1, 3, 3, 10, 1, 0, 0);
        n_checks++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00)
            $display("FAIL b2b_gap2 a=%0d b=%0d required 0/0", fwd_a_sel, fwd_b_sel);
        else n_pass++;
    endtask

    task automatic test_load_use();
        int cnt0;
        do_reset();
        cnt0 = int'(stall_count);
        cycle(1, 1, 0, 5, 1, 1, 0);
        cycle(1, 5, 2, 6, 1, 0, 0);
        n_checks++;
        if (act_stall !== 1'b1 || fwd_a_sel !== 2'b00)
            $display("FAIL lu_stall stall=%0b a=%0d required 1/0", act_stall, fwd_a_sel);
        else n_pass++;
        cycle(1, 5, 2, 6, 1, 0, 0);
        n_checks++;
        if (act_stall !== 1'b0 || fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b00)
            $display("FAIL lu_after stall=%0b a=%0d b=%0d required 0/2/0",
                     act_stall, fwd_a_sel, fwd_b_sel);
        else n_pass++;
        n_checks++;
        if (int'(stall_count) !== cnt0 + 1)
            $display("FAIL lu_count actual=%0d required=%0d", stall_count, cnt0 + 1);
        else n_pass++;
    endtask

    task automatic test_zero_src();
        do_reset();
        cycle(1, 1, 2, 0, 1, 0, 0);
        cycle(1, 0, 0, 4, 1, 0, 0);
        n_checks++;
        if (act_stall !== 1'b0 || fwd_a_sel !== 2'b11 || fwd_b_sel !== 2'b11)
            $display("FAIL zero_alu stall=%0b a=%0d b=%0d required 0/3/3",
                     act_stall, fwd_a_sel, fwd_b_sel);
        else n_pass++;
        cycle(1, 1, 2, 0, 1, 1, 0);
        cycle(1, 0, 0, 4, 1, 0, 0);
        n_checks++;
        if (act_stall !== 1'b0 || fwd_a_sel !== 2'b11 || fwd_b_sel !== 2'b11)
            $display("FAIL zero_load stall=%0b a=%0d b=%0d required 0/3/3",
                     act_stall, fwd_a_sel, fwd_b_sel);
        else n_pass++;
    endtask

    task automatic test_priority();
        do_reset();
        cycle(1, 1, 2, 7, 1, 0, 0);
        cycle(1, 3, 4, 7, 1, 0, 0);
        cycle(1, 7, 7, 11, 1, 0, 0);
        n_checks++;
        if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b01)
            $display("FAIL priority a=%0d b=%0d required 1/1", fwd_a_sel, fwd_b_sel);
        else n_pass++;
    endtask

    task automatic test_flush();
        int cnt0;
        do_reset();
        cnt0 = int'(stall_count);
        cycle(1, 1, 0, 5, 1, 1, 0);
        cycle(1, 5, 5, 6, 1, 0, 1);
        n_checks++;
        if (act_stall !== 1'b0 || fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00)
            $display("FAIL flush_lu stall=%0b a=%0d b=%0d required 0/0/0",
                     act_stall, fwd_a_sel, fwd_b_sel);
        else n_pass++;
        n_checks++;
        if (int'(stall_count) !== cnt0)
            $display("FAIL flush_count actual=%0d required=%0d", stall_count, cnt0);
        else n_pass++;
        cycle(1, 6, 5, 7, 1, 0, 0);
        n_checks++;
        if (act_stall !== 1'b0 || fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b10)
            $display("FAIL flush_bubble stall=%0b a=%0d b=%0d required 0/0/2",
                     act_stall, fwd_a_sel, fwd_b_sel);
        else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            cycle(1, 1, 0, 5, 1, 1, 0);
            cycle(1, 2, 5, 6, 1, 0, 0);
            cycle(1, 2, 5, 6, 1, 0, 0);
        end
        n_checks++;
        if (int'(stall_count) !== CNT_MAX || exp_cnt !== CNT_MAX)
            $display("FAIL sat_count actual=%0d required=%0d", stall_count, CNT_MAX);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (stall_count !== '0)
            $display("FAIL sat_reset actual=%0d required=0", stall_count);
        else n_pass++;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 7) != 0, $urandom_range(0, 5), $urandom_range(0, 5),
                  $urandom_range(0, 5), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1), $urandom_range(0, 9) == 0);
            n_checks++;
            if (act_stall !== exp_stall || int'(fwd_a_sel) !== exp_a ||
                int'(fwd_b_sel) !== exp_b || int'(stall_count) !== exp_cnt) begin
                if (bad < 10)
                    $display("FAIL random[%0d] stall=%0b a=%0d b=%0d cnt=%0d required %0b/%0d/%0d/%0d",
                             i, act_stall, fwd_a_sel, fwd_b_sel, stall_count,
                             exp_stall, exp_a, exp_b, exp_cnt);
                bad++;
            end else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        model_reset();
        test_reset();
        test_back_to_back();
        test_load_use();
        test_zero_src();
        test_priority();
        test_flush();
        test_saturation();
        test_random();
        idle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Generates the operand-forwarding select codes and the load-use stall for the 5-stage MIPS pipeline, i.e. the control end that drives the two 4:1 32-bit ALU-operand forwarding muxes. It keeps a shadow pipeline of destination-register and write-enable information for the instructions in EX, MEM and WB. It registers the select codes as an instruction moves from ID to EX, so the codes are aligned with the ID/EX data register. It sits beside the ID/EX pipeline register and feeds the PC/IF-ID enables with `stall`.

## Interface
- `REG_W`, default 5: register-specifier width.
- `CNT_W`, default 16: width of the stall statistics counter.

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `id_valid`, input, 1: the ID stage holds a real instruction.
- `id_rs`, input, REG_W: source register for operand A of the instruction in ID.
- `id_rt`, input, REG_W: source register for operand B of the instruction in ID.
- `id_dest`, input, REG_W: destination register of the instruction in ID.
- `id_reg_write`, input, 1: the ID instruction writes `id_dest`.
- `id_mem_read`, input, 1: the ID instruction is a load.
- `flush`, input, 1: squash the ID instruction (branch taken or jump).
- `fwd_a_sel`, output, 2: operand-A mux select for the instruction currently in EX.
- `fwd_b_sel`, output, 2: operand-B mux select for the instruction currently in EX.
- `stall`, output, 1: hold PC and IF/ID, and insert a bubble into ID/EX.
- `stall_count`, output, CNT_W: saturating count of stall cycles.

## Operation
- **Select encoding:**
  - 00: register-file value.
  - 01: EX/MEM result.
  - 10: MEM/WB result.
  - 11: constant zero.
- **Shadow entries:** there are three, `ex`, `mem` and `wb`. Each holds {valid, dest, reg_write, mem_read}.
- **Hazard matches:** a source register S "hits" entry E when E.valid & E.reg_write & E.dest == S & S != 0.
- **Per-operand priority**, evaluated on the ID source at the advancing edge:
  1. S == 0 gives 11.
  2. Hit on `ex` gives 01. That instruction will be in MEM when the consumer is in EX.
  3. Hit on `mem` gives 10.
  4. Otherwise 00. A hit on `wb` resolves through the register file's write-before-read.
- **Load-use stall:** `stall` = id_valid & !flush & `ex`.mem_read & (rs hits `ex` | rt hits `ex`).
  - Combinational from the registered `ex` entry and the ID inputs.
  - A stall lasts exactly one cycle. After the bubble, the load sits in `mem` and the consumer gets select 10.
- **Per-edge update (no reset):**
  - `wb` <= `mem`, and `mem` <= `ex`, always.
  - If flush or stall or !id_valid: `ex` <= bubble (valid=0), and both selects <= 00.
  - Otherwise: `ex` <= {1, id_dest, id_reg_write, id_mem_read}, and the selects <= the priority results.
- **Simultaneous events:**
  - flush and stall conditions together: flush wins. `stall` is 0 and a bubble is inserted.
  - rs == rt: both selects take the same code.
  - A hit on both `ex` and `mem`: 01, the youngest producer, wins.
- **stall_count:** increments on every edge where `stall` = 1. It saturates at all-ones and does not wrap.
- **Reset:** all shadow valid bits = 0, `fwd_a_sel` = `fwd_b_sel` = 00, `stall_count` = 0, and `stall` evaluates to 0.
  - Reset asserted mid-stream discards all in-flight hazard information immediately, without waiting for a clock edge.

## Timing
- Select latency is 1 cycle. The codes computed from ID inputs at edge N are valid from edge N until edge N+1, the same cycle the ID/EX register presents that instruction's data.
- `stall` is same-cycle combinational. PC, IF/ID and this block's `ex` bubble insertion all act at the next edge.
- No multicycle paths. Critical path: `ex`.dest compare to `stall` to the PC enable.

## Structure
- Shared package `mips_fwd_pkg` holds:
  - Constants FWD_REG = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10, FWD_ZERO = 2'b11.
  - The shadow-entry struct {valid, dest, reg_write, mem_read}.
  - The REG_W default.
- One sub-module, `fwd_operand_sel`, which is combinational priority logic for a single source register against the `ex` and `mem` entries. It is instantiated twice, for rs and rt, and also outputs its `ex`-load hit for the stall term.

## Test plan
- **Reset:** pulse rst mid-stream with a load in `ex` -> selects 00, stall 0 and stall_count 0 immediately, with no clock edge needed.
- **Back-to-back ALU:** `add $3` then `sub rs=$3, rt=$4` -> fwd_a_sel = 01 and fwd_b_sel = 00 in the sub's EX cycle. Add one independent instruction in between -> fwd_a_sel = 10.
- **Load-use:** `lw $5` then `add rs=$5` -> stall = 1 for exactly one cycle, a bubble enters EX, fwd_a_sel = 10 when the add reaches EX, and stall_count = 1.
- **$0 source:** `add $0`(reg_write=1) then `or rs=$0, rt=$0` -> both selects = 11 and no stall, even if the producer is a load to $0.
- **Priority:** producers of $7 in both `ex` and `mem`, consumer with rs=rt=$7 -> both selects 01.
- **Flush during load-use:** load-use condition with flush = 1 -> stall 0, the `ex` entry is a bubble, selects 00 next cycle, and stall_count unchanged. Separately, drive 2^CNT_W+3 stall cycles -> stall_count holds at all-ones.
